mod_mul_il_v2: RTL and testbench
================================

MOD_MUL_IL_V2 -- requirements
Module: mod_mul_il_v2

Interface
REQ-001 The block SHALL have parameter NBITS, default 256, giving the operand/modulus width in bits; legal range 2..4096.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operand set (a, b, m) valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept an operand set.
REQ-006 The block SHALL have ports a, b and m, each input, NBITS wide: multiplicand, multiplier and modulus, sampled on acceptance.
REQ-007 The block SHALL have port y, output, NBITS wide: result a*b mod m, meaningful only while out_valid=1.
REQ-008 The block SHALL have port err, output, 1 bit: illegal operands, meaningful only while out_valid=1.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 The block SHALL have port done_irq_p, output, 1 bit: single-cycle completion pulse.

Function
REQ-012 The block SHALL implement the FSM states IDLE, CHECK, RUN and DONE.
REQ-013 The block SHALL drive in_ready=1 only in IDLE and SHALL accept an operand set on an edge where in_valid=1 and in_ready=1.
REQ-014 On acceptance the block SHALL register a, b and m internally and move IDLE->CHECK; later changes on a, b, m SHALL have no effect.
REQ-015 In CHECK the block SHALL flag an error when m==0, a>=m or b>=m (unsigned compare).
REQ-016 On a CHECK error it SHALL go to DONE with y=0 and err=1.
REQ-017 On a clean CHECK it SHALL go to RUN with P=0 and bit index i=NBITS-1.
REQ-018 On each RUN edge the block SHALL compute P <= R(R(2P + a[i]*b)), where R(v) = v-m if v>=m else v, then decrement i.
REQ-019 The block SHALL process bits MSB first, exactly NBITS RUN cycles, then go to DONE with y=P and err=0.
REQ-020 The internal datapath SHALL be NBITS+2 bits wide so that 2P+b < 3m never overflows; P SHALL satisfy P < m after every RUN edge.
REQ-021 Latency SHALL be fixed: out_valid rises NBITS+2 edges after the acceptance edge for legal operands and 2 edges after it for an error.
REQ-022 Latency SHALL be independent of operand values; there SHALL be no early exit.
REQ-023 The block SHALL hold out_valid=1 and y/err stable in DONE until an edge with out_ready=1, then move DONE->IDLE.
REQ-024 in_ready SHALL be 1 on the cycle after the handshake; no same-cycle result-pop and operand-accept.
REQ-025 done_irq_p SHALL be 1 for exactly the first cycle of each DONE visit, including error completions, regardless of out_ready.
REQ-026 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT be captured later unless still asserted when in_ready=1.
REQ-027 When NBITS=2 the block SHALL behave as specified, with 2 RUN cycles.

Reset
REQ-028 While rst=1 at an edge the block SHALL enter IDLE, set P=0, y=0, err=0, out_valid=0, done_irq_p=0 and in_ready=1 from the following cycle.
REQ-029 Reset asserted in CHECK, RUN or DONE SHALL abandon the operation without producing out_valid or done_irq_p.
REQ-030 The first operand set after reset SHALL be accepted normally.

Verification (NBITS=8 unless stated)
REQ-031 Basic: a=7, b=9, m=13 -> y=11, err=0, out_valid exactly 10 edges after accept, one done_irq_p pulse.
REQ-032 Wrap and maximum: a=254, b=254, m=255 -> y=1; a=12, b=12, m=13 -> y=1; a=0, b=200, m=201 -> y=0 with full latency.
REQ-033 Error: a=13, b=5, m=13 -> err=1, y=0 after 2 edges; m=0 -> err=1; a=0, b=0, m=1 -> y=0, err=0.
REQ-034 Backpressure: out_ready held 0 for 20 cycles -> y/out_valid stable, in_ready=0, a second in_valid is ignored; after out_ready=1, in_ready=1 next cycle and a new set is accepted.
REQ-035 Reset mid-RUN at edge 4 -> no out_valid or done_irq_p, in_ready=1 after reset; a new a=3, b=5, m=7 -> y=1.
REQ-036 Random: NBITS=64 and NBITS=256, 10k random legal sets with m odd and even -> y matches a reference a*b mod m.

Source files
------------

// File: rtl/mod_mul_il_v2.sv
// Sequential interleaved modular multiplier: y = a*b mod m, one multiplier bit per cycle, MSB first.
// Fixed latency regardless of operand values; errors on m==0, a>=m or b>=m.
module mod_mul_il_v2 #(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  output logic [NBITS-1:0] y,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done_irq_p
);

  localparam int W  = NBITS + 2;
  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t           state;
  logic [NBITS-1:0] a_sh;
  logic [NBITS-1:0] b_r;
  logic [NBITS-1:0] m_r;
  logic [W-1:0]     p;
  logic [W-1:0]     p_next;
  logic [W-1:0]     m_ext;
  logic [W-1:0]     v_sum;
  logic [W-1:0]     v_red;
  logic [CW-1:0]    cnt;
  logic             chk_phase;
  logic             chk_bad;

  // One interleaved step: 2P + bit*b is below 3m, so two conditional subtracts restore P < m.
  always_comb begin
    m_ext  = {2'b00, m_r};
    v_sum  = (p << 1) + (a_sh[NBITS-1] ? {2'b00, b_r} : '0);
    v_red  = (v_sum >= m_ext) ? v_sum - m_ext : v_sum;
    p_next = (v_red >= m_ext) ? v_red - m_ext : v_red;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_r        <= '0;
      m_r        <= '0;
      p          <= '0;
      cnt        <= '0;
      chk_phase  <= 1'b0;
      chk_bad    <= 1'b0;
      y          <= '0;
      err        <= 1'b0;
      out_valid  <= 1'b0;
      done_irq_p <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      done_irq_p <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh      <= a;
            b_r       <= b;
            m_r       <= m;
            chk_phase <= 1'b0;
            in_ready  <= 1'b0;
            state     <= CHECK;
          end
        end
        // Wide magnitude compares get a cycle of their own before the branch.
        CHECK: begin
          if (!chk_phase) begin
            chk_bad   <= (m_r == '0) || (a_sh >= m_r) || (b_r >= m_r);
            chk_phase <= 1'b1;
          end else if (chk_bad) begin
            y          <= '0;
            err        <= 1'b1;
            out_valid  <= 1'b1;
            done_irq_p <= 1'b1;
            state      <= DONE;
          end else begin
            p     <= '0;
            cnt   <= CW'(NBITS - 1);
            state <= RUN;
          end
        end
        RUN: begin
          p    <= p_next;
          a_sh <= a_sh << 1;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            y          <= p_next[NBITS-1:0];
            err        <= 1'b0;
            out_valid  <= 1'b1;
            done_irq_p <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_il_v2.sv
// Directed bench for mod_mul_il_v2 at NBITS=8 (vector table + corner sequences)
// plus a short batch of random legal operand sets on an NBITS=64 instance.
module tb_mod_mul_il_v2;

  localparam int N  = 8;
  localparam int N2 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, err, out_valid, out_ready, done_irq_p;
  logic [N-1:0]  a, b, m, y;
  logic          in_valid_w, in_ready_w, err_w, out_valid_w, out_ready_w, done_irq_p_w;
  logic [N2-1:0] a_w, b_w, m_w, y_w;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] vm;
    logic [7:0] ey;
    logic       eerr;
    int         elat;
  } vec_t;

  vec_t vecs[12];

  mod_mul_il_v2 #(.NBITS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .y(y), .err(err), .out_valid(out_valid),
    .out_ready(out_ready), .done_irq_p(done_irq_p)
  );

  mod_mul_il_v2 #(.NBITS(N2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .m(m_w), .y(y_w), .err(err_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .done_irq_p(done_irq_p_w)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one operand set for exactly one edge, then scramble the inputs.
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vm);
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = va; b = vb; m = vm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~va; b = ~vb; m = ~vm;
  endtask

  task automatic waitValid(output int lat, output int irqs);
    lat = 0; irqs = 0;
    while (!out_valid && lat < N + 20) begin
      @(posedge clk); #1;
      lat++;
      if (done_irq_p) irqs++;
    end
  endtask

  task automatic popResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input string tag);
    int lat, irqs;
    applyStimulus(v.va, v.vb, v.vm);
    waitValid(lat, irqs);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(v.elat));
    checkOutput({tag, "_irq_count"}, 64'(irqs), 64'd1);
    checkOutput({tag, "_irq_first"}, 64'(done_irq_p), 64'd1);
    checkOutput({tag, "_y"}, 64'(y), 64'(v.ey));
    checkOutput({tag, "_err"}, 64'(err), 64'(v.eerr));
    @(posedge clk); #1;
    checkOutput({tag, "_irq_drop"}, 64'(done_irq_p), 64'd0);
    checkOutput({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, "_hold_y"}, 64'(y), 64'(v.ey));
    popResult();
    checkOutput({tag, "_pop_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_pop_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, irqs, seen;
    vec_t v;
    logic [63:0]  ra, rb, rm;
    logic [127:0] prod;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; m = '0;
    in_valid_w = 1'b0; out_ready_w = 1'b0; a_w = '0; b_w = '0; m_w = '0;

    vecs[0]  = '{8'd7,   8'd9,   8'd13,  8'd11,  1'b0, 10};
    vecs[1]  = '{8'd254, 8'd254, 8'd255, 8'd1,   1'b0, 10};
    vecs[2]  = '{8'd12,  8'd12,  8'd13,  8'd1,   1'b0, 10};
    vecs[3]  = '{8'd0,   8'd200, 8'd201, 8'd0,   1'b0, 10};
    vecs[4]  = '{8'd13,  8'd5,   8'd13,  8'd0,   1'b1, 2};
    vecs[5]  = '{8'd1,   8'd1,   8'd0,   8'd0,   1'b1, 2};
    vecs[6]  = '{8'd0,   8'd0,   8'd1,   8'd0,   1'b0, 10};
    vecs[7]  = '{8'd3,   8'd5,   8'd7,   8'd1,   1'b0, 10};
    vecs[8]  = '{8'd5,   8'd13,  8'd13,  8'd0,   1'b1, 2};
    vecs[9]  = '{8'd100, 8'd200, 8'd251, 8'd171, 1'b0, 10};
    vecs[10] = '{8'd255, 8'd2,   8'd255, 8'd0,   1'b1, 2};
    vecs[11] = '{8'd200, 8'd3,   8'd255, 8'd90,  1'b0, 10};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_irq", 64'(done_irq_p), 64'd0);
    checkOutput("reset_y", 64'(y), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held, in_ready low, stray in_valid ignored.
    applyStimulus(8'd7, 8'd9, 8'd13);
    waitValid(lat, irqs);
    checkOutput("bp_latency", 64'(lat), 64'd10);
    checkOutput("bp_y_first", 64'(y), 64'd11);
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 10); a = 8'd1; b = 8'd1; m = 8'd3;
      @(posedge clk); #1;
      checkOutput($sformatf("bp_valid_%0d", c), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp_y_%0d", c), 64'(y), 64'd11);
      checkOutput($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
      checkOutput($sformatf("bp_irq_%0d", c), 64'(done_irq_p), 64'd0);
    end
    in_valid = 1'b0;
    popResult();
    checkOutput("bp_pop_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_pop_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("bp_stray_not_captured", 64'(in_ready), 64'd1);
    v = '{8'd3, 8'd5, 8'd7, 8'd1, 1'b0, 10};
    runVector(v, "bp_next");

    // Reset four edges after acceptance, while in RUN.
    applyStimulus(8'd100, 8'd200, 8'd251);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_irq", 64'(done_irq_p), 64'd0);
    seen = 0;
    repeat (N + 6) begin
      @(posedge clk); #1;
      if (out_valid || done_irq_p) seen++;
    end
    checkOutput("midrst_no_output", 64'(seen), 64'd0);
    runVector(v, "midrst_next");

    // Random legal sets on the 64-bit instance, alternating odd and even moduli.
    for (int i = 0; i < 12; i++) begin
      rm = {$urandom, $urandom};
      rm[0] = ~i[0];
      if (rm < 64'd2) rm = 64'd2;
      ra = {$urandom, $urandom} % rm;
      rb = {$urandom, $urandom} % rm;
      prod = ({64'd0, ra} * {64'd0, rb}) % {64'd0, rm};
      checkOutput($sformatf("w%0d_in_ready", i), 64'(in_ready_w), 64'd1);
      a_w = ra; b_w = rb; m_w = rm; in_valid_w = 1'b1;
      @(posedge clk); #1;
      in_valid_w = 1'b0; a_w = '0; b_w = '0; m_w = '0;
      lat = 0;
      while (!out_valid_w && lat < N2 + 20) begin
        @(posedge clk); #1;
        lat++;
      end
      checkOutput($sformatf("w%0d_latency", i), 64'(lat), 64'(N2 + 2));
      checkOutput($sformatf("w%0d_y", i), y_w, prod[63:0]);
      checkOutput($sformatf("w%0d_err", i), 64'(err_w), 64'd0);
      out_ready_w = 1'b1;
      @(posedge clk); #1;
      out_ready_w = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
